// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch/sequencer stage that sits in front of the execute stage.
//   It owns the program counter and reads instruction words from instruction
//   memory over a req/ack handshake. Each word is issued for one cycle on
//   ireg. After that the stage waits one cycle so that execute can return its
//   PSR, and then resolves BRA against that PSR. HLT stops the sequencer.
//   Unknown opcodes sequence the same way as a NOP.
//
//   Handshake: imem_req is held high and imem_addr is held stable until
//   imem_ack is seen high on a rising edge while in FETCH. imem_rdata is
//   captured on that same edge. imem_ack is ignored in every other state.
//   The same-cycle ack of a 1-cycle memory is accepted.
//
// Ports
//   clk         system clock; all state changes on the rising edge
//   reset       synchronous, active-high reset
//   start       1-cycle pulse; starts fetching at START_PC (from IDLE/HALTED)
//   imem_req    instruction read request
//   imem_addr   read address (equal to pc; stable while imem_req=1)
//   imem_ack    read data valid this cycle
//   imem_rdata  instruction word, valid together with imem_ack
//   ireg        instruction register presented to execute
//   ireg_valid  ireg is new this cycle (one cycle per instruction)
//   psr_in      PSR from execute: [0]carry [1]parity [2]even [3]neg [4]zero
//   pc          current program counter
//   halted      high while the sequencer is stopped on HLT
//   dbgState    current FSM state, for observation only
// ---------------------------------------------------------------------------
module fetch_unit #(
   parameter int              IRW      = 32,
   parameter int              PCW      = 12,
   parameter int              PSRW     = 5,
   parameter logic [PCW-1:0]  START_PC = '0,
   parameter logic [3:0]      BRA      = 4'h3,
   parameter logic [3:0]      HLT      = 4'h8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   output logic            imem_req,
   output logic [PCW-1:0]  imem_addr,
   input  logic            imem_ack,
   input  logic [IRW-1:0]  imem_rdata,
   output logic [IRW-1:0]  ireg,
   output logic            ireg_valid,
   input  logic [PSRW-1:0] psr_in,
   output logic [PCW-1:0]  pc,
   output logic            halted,
   output logic [2:0]      dbgState
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH   = 3'd1,
      ISSUE   = 3'd2,
      RESOLVE = 3'd3,
      HALTED  = 3'd4
   } state_t;

   state_t state;

   logic [3:0]     op;
   logic [3:0]     cc;
   logic [PCW-1:0] target;
   logic           taken;

   assign dbgState  = state;
   // pc only changes outside FETCH, so the address stays stable for the
   // whole request.
   assign imem_addr = pc;

   assign op     = ireg[IRW-1 -: 4];
   assign cc     = ireg[IRW-5 -: 4];
   assign target = ireg[PCW-1:0];

   // Branch condition decode. ireg is held through RESOLVE, so cc is valid
   // in the same cycle that psr_in reflects the issued instruction.
   always_comb begin
      taken = 1'b0;
      case (cc)
         4'd0:    taken = 1'b1;
         4'd1:    taken = psr_in[1];
         4'd2:    taken = psr_in[2];
         4'd3:    taken = psr_in[0];
         4'd4:    taken = psr_in[3];
         4'd5:    taken = psr_in[4];
         4'd6:    taken = ~psr_in[0];
         4'd7:    taken = ~psr_in[3];
         default: taken = 1'b0;
      endcase
   end

   // All outputs are registered. Each one is set on the edge that enters
   // the state it belongs to.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         pc         <= START_PC;
         ireg       <= '0;
         imem_req   <= 1'b0;
         ireg_valid <= 1'b0;
         halted     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= FETCH;
                  pc       <= START_PC;
                  imem_req <= 1'b1;
               end
            end
            FETCH: begin
               if (imem_ack) begin
                  ireg       <= imem_rdata;
                  pc         <= pc + PCW'(1);
                  imem_req   <= 1'b0;
                  ireg_valid <= 1'b1;
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               ireg_valid <= 1'b0;
               state      <= RESOLVE;
            end
            RESOLVE: begin
               if (op == HLT) begin
                  halted <= 1'b1;
                  state  <= HALTED;
               end else begin
                  // When the branch is not taken, pc already points at the
                  // next sequential word.
                  if (op == BRA && taken) begin
                     pc <= target;
                  end
                  imem_req <= 1'b1;
                  state    <= FETCH;
               end
            end
            HALTED: begin
               if (start) begin
                  pc       <= START_PC;
                  halted   <= 1'b0;
                  imem_req <= 1'b1;
                  state    <= FETCH;
               end
            end
            default: begin
               state      <= IDLE;
               imem_req   <= 1'b0;
               ireg_valid <= 1'b0;
               halted     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//   Bench for fetch_unit. A program model walks the memory image by the
//   architectural rules (sequential pc, BRA condition table, HLT stop). It
//   produces the expected fetch-address sequence and the expected issued-word
//   sequence. One compare process checks the DUT against these on every
//   cycle. Directed tests add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

   localparam logic [31:0] HLT_W = 32'h8000_0000;

   logic        clk;
   logic        reset;
   logic        start;
   logic        imem_req;
   logic [11:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] ireg;
   logic        ireg_valid;
   logic [4:0]  psr_in;
   logic [11:0] pc;
   logic        halted;
   logic [2:0]  dbgState;

   fetch_unit dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .ireg       (ireg),
      .ireg_valid (ireg_valid),
      .psr_in     (psr_in),
      .pc         (pc),
      .halted     (halted),
      .dbgState   (dbgState)
   );

   // ---------------- clock / cycle counter ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- bookkeeping ----------------
   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // ---------------- memory responder ----------------
   logic [31:0] mem [0:4095];
   int          ackDelay = 0;
   bit          memAuto  = 1'b1;
   logic        manAck   = 1'b0;
   logic [31:0] manData  = '0;
   int          waitCnt  = 0;

   initial begin
      imem_ack   = 1'b0;
      imem_rdata = '0;
   end

   always @(negedge clk) begin
      if (!memAuto) begin
         imem_ack = manAck;
         imem_rdata = manData;
         waitCnt = 0;
      end else if (imem_req) begin
         if (waitCnt >= ackDelay) begin
            imem_ack = 1'b1;
            imem_rdata = mem[imem_addr];
         end else begin
            imem_ack = 1'b0;
         end
         waitCnt++;
      end else begin
         imem_ack = 1'b0;
         waitCnt = 0;
      end
   end

   // ---------------- program model ----------------
   logic [11:0] expAddrQ[$];
   logic [31:0] expIregQ[$];
   logic [11:0] modelPc;

   function automatic logic branchTaken(input logic [3:0] c, input logic [4:0] p);
      case (c)
         4'd0:    return 1'b1;
         4'd1:    return p[1];
         4'd2:    return p[2];
         4'd3:    return p[0];
         4'd4:    return p[3];
         4'd5:    return p[4];
         4'd6:    return !p[0];
         4'd7:    return !p[3];
         default: return 1'b0;
      endcase
   endfunction

   // The PSR is psrA until the instruction at swAddr has executed, and psrB
   // after that.
   task automatic buildModel(input logic [4:0] psrA, input logic [4:0] psrB, input logic [11:0] swAddr);
      logic [11:0] mpc;
      logic [11:0] at;
      logic [4:0]  p;
      logic [31:0] w;
      expAddrQ.delete();
      expIregQ.delete();
      mpc = 12'h000;
      p = psrA;
      for (int n = 0; n < 64; n++) begin
         at = mpc;
         w = mem[at];
         expAddrQ.push_back(at);
         expIregQ.push_back(w);
         mpc = at + 12'd1;
         if (w[31:28] == 4'h8) break;
         if (w[31:28] == 4'h3 && branchTaken(w[27:24], p)) mpc = w[11:0];
         if (at == swAddr) p = psrB;
      end
      modelPc = mpc;
   endtask

   // ---------------- compare process ----------------
   bit          chkEn = 1'b0;
   int          startCyc = 0;
   int          haltCyc = -1;
   logic [11:0] obsAddr[$];
   int          validCyc[$];
   logic        prevReq = 1'b0;
   logic        prevValid = 1'b0;
   logic        prevHalted = 1'b0;
   logic [11:0] prevAddr = '0;

   always @(negedge clk) begin
      if (chkEn) begin
         if (imem_req && !prevReq) begin
            obsAddr.push_back(imem_addr);
            if (expAddrQ.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL fetch_addr: request at %h, expected no request", imem_addr);
            end else begin
               check("fetch_addr", imem_addr, expAddrQ.pop_front());
            end
         end
         if (imem_req && prevReq) check("addr_stable", imem_addr, prevAddr);
         if (ireg_valid) begin
            validCyc.push_back(cyc - startCyc);
            check("valid_single_cycle", prevValid, 1'b0);
            check("req_low_in_issue", imem_req, 1'b0);
            if (expIregQ.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL issue_word: issued %h, expected no issue", ireg);
            end else begin
               check("issue_word", ireg, expIregQ.pop_front());
            end
         end
         if (halted) check("req_low_when_halted", imem_req, 1'b0);
         if (halted && !prevHalted) haltCyc = cyc - startCyc;
      end
      prevReq = imem_req;
      prevValid = ireg_valid;
      prevHalted = halted;
      prevAddr = imem_addr;
   end

   // ---------------- driver tasks ----------------
   task automatic clearMem();
      for (int i = 0; i < 4096; i++) mem[i] = 32'h0000_0000;
   endtask

   function automatic logic [31:0] braWord(input logic [3:0] c, input logic [11:0] dst);
      return {4'h3, c, 12'h000, dst};
   endfunction

   task automatic runProg(input string tag, input int dly, input logic [4:0] psrA,
                          input logic [4:0] psrB, input logic [11:0] swAddr,
                          input logic [31:0] swWord, input bit pulseInFetch);
      bit done = 1'b0;
      bit pulsed = 1'b0;
      buildModel(psrA, psrB, swAddr);
      ackDelay = dly;
      memAuto = 1'b1;
      psr_in = psrA;
      obsAddr.delete();
      validCyc.delete();
      haltCyc = -1;
      @(posedge clk); #1;
      start = 1'b1;
      startCyc = cyc;
      chkEn = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < 400 && !done; k++) begin
         @(negedge clk);
         if (start) start = 1'b0;
         if (pulseInFetch && !pulsed && imem_req && (cyc - startCyc) == 2) begin
            start = 1'b1;
            pulsed = 1'b1;
         end
         if (ireg_valid && ireg === swWord) psr_in = psrB;
         if (halted) done = 1'b1;
      end
      if (!done) $display("FAIL %s_timeout: state %0d, halted never seen, expected halted 1", tag, dbgState);
      check({tag, "_halted"}, halted, 1'b1);
      @(posedge clk); #1;
      chkEn = 1'b0;
      check({tag, "_addr_left"}, expAddrQ.size(), 0);
      check({tag, "_issue_left"}, expIregQ.size(), 0);
      check({tag, "_final_pc"}, pc, modelPc);
   endtask

   // ---------------- directed tests ----------------
   initial begin
      reset = 1'b1;
      start = 1'b0;
      psr_in = '0;
      clearMem();
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      check("rst_pc", pc, 12'h000);
      check("rst_req", imem_req, 1'b0);
      check("rst_valid", ireg_valid, 1'b0);
      check("rst_halted", halted, 1'b0);
      check("rst_ireg", ireg, 32'h0);

      // T2: ADD, HLT with a 1-cycle memory. HLT issues in cycle 5 and is
      // resolved in cycle 6, so HALTED starts in cycle 7.
      clearMem();
      mem[0] = 32'h1000_0005;
      mem[1] = HLT_W;
      runProg("t2", 0, 5'b00000, 5'b00000, 12'hABC, 32'hFFFF_FFFF, 1'b0);
      check("t2_valid_count", validCyc.size(), 2);
      if (validCyc.size() == 2) begin
         check("t2_valid_cyc0", validCyc[0], 2);
         check("t2_valid_cyc1", validCyc[1], 5);
      end
      check("t2_halt_cyc", haltCyc, 7);
      check("t2_pc", pc, 12'h002);
      check("t2_ireg_held", ireg, HLT_W);

      // T3: BRA on zero to 0x040, taken and not taken.
      clearMem();
      for (int i = 0; i < 5; i++) mem[i] = 32'h0100_0000 | i;
      mem[5] = braWord(4'd5, 12'h040);
      mem[12'h040] = HLT_W;
      mem[6] = HLT_W;
      runProg("t3a", 0, 5'b10000, 5'b10000, 12'hABC, 32'hFFFF_FFFF, 1'b0);
      if (obsAddr.size() > 6) check("t3a_branch_addr", obsAddr[6], 12'h040);
      else check("t3a_fetch_count", obsAddr.size(), 7);
      runProg("t3b", 0, 5'b00000, 5'b00000, 12'hABC, 32'hFFFF_FFFF, 1'b0);
      if (obsAddr.size() > 6) check("t3b_fall_addr", obsAddr[6], 12'h006);
      else check("t3b_fetch_count", obsAddr.size(), 7);

      // T4: no-carry with carry set (not taken), always (taken), cc=9 (never).
      clearMem();
      mem[0] = braWord(4'd6, 12'h100);
      mem[1] = braWord(4'd0, 12'h200);
      mem[12'h200] = braWord(4'd9, 12'h300);
      mem[12'h201] = HLT_W;
      mem[12'h100] = HLT_W;
      mem[12'h300] = HLT_W;
      runProg("t4", 0, 5'b00001, 5'b00001, 12'hABC, 32'hFFFF_FFFF, 1'b0);
      check("t4_pc", pc, 12'h202);

      // T5: jump to 0xFFF; the non-branch there wraps pc to 0x000. The
      // zero flag is then cleared, so the second BRA at 0 falls through to HLT.
      clearMem();
      mem[0] = braWord(4'd5, 12'hFFF);
      mem[1] = HLT_W;
      mem[12'hFFF] = 32'h1000_0FFF;
      runProg("t5", 0, 5'b10000, 5'b00000, 12'hFFF, 32'h1000_0FFF, 1'b0);
      if (obsAddr.size() > 2) begin
         check("t5_addr_fff", obsAddr[1], 12'hFFF);
         check("t5_wrap_addr", obsAddr[2], 12'h000);
      end else check("t5_fetch_count", obsAddr.size(), 4);

      // T6: ack delayed by 4 cycles, with start pulsed during FETCH.
      clearMem();
      mem[0] = 32'h1000_0005;
      mem[1] = HLT_W;
      runProg("t6", 4, 5'b00000, 5'b00000, 12'hABC, 32'hFFFF_FFFF, 1'b1);
      if (validCyc.size() > 0) check("t6_first_valid_cyc", validCyc[0], 6);
      else check("t6_valid_count", validCyc.size(), 2);

      // T1: reset during a FETCH at pc=1; an ack after the reset is ignored.
      memAuto = 1'b0;
      manAck = 1'b0;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      manAck = 1'b1;
      manData = 32'h1234_5678;
      @(posedge clk); #1 manAck = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("t1_pre_req", imem_req, 1'b1);
      check("t1_pre_pc", pc, 12'h001);
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      check("t1_req", imem_req, 1'b0);
      check("t1_pc", pc, 12'h000);
      check("t1_halted", halted, 1'b0);
      check("t1_valid", ireg_valid, 1'b0);
      check("t1_ireg", ireg, 32'h0);
      manAck = 1'b1;
      manData = HLT_W;
      @(posedge clk); #1 manAck = 1'b0;
      check("t1_late_ack_ireg", ireg, 32'h0);
      check("t1_late_ack_valid", ireg_valid, 1'b0);
      @(posedge clk); #1;
      check("t1_idle_req", imem_req, 1'b0);
      check("t1_idle_valid", ireg_valid, 1'b0);
      check("t1_idle_halted", halted, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
